// File: rtl/kmap_eval_arbiter.sv
// kmap_eval_arbiter: a shared 4-input truth-table evaluator, f = TABLE[x], with
// round-robin arbitration across N_REQ requesters, a single registered response
// slot with backpressure, runtime table reprogramming and a 16-step self-scan
// that returns the full evaluated map.
module kmap_eval_arbiter #(
    parameter int          N_REQ       = 4,
    parameter int          ID_W        = 2,
    parameter logic [15:0] RESET_TABLE = 16'hD073
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [4*N_REQ-1:0]   req_x,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    output logic                 rsp_f,
    output logic [3:0]           rsp_x,
    output logic [ID_W-1:0]      rsp_id,
    input  logic                 rsp_ready,
    input  logic                 cfg_we,
    input  logic [15:0]          cfg_table,
    input  logic                 scan_start,
    output logic                 scan_busy,
    output logic                 scan_done,
    output logic [15:0]          scan_map
);

    typedef enum logic [1:0] {IDLE, SCAN, SDONE} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             table_q, table_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [3:0]              scan_x_q, scan_x_d;
    logic [15:0]             scan_map_q, scan_map_d;
    logic                    scan_busy_q, scan_busy_d;
    logic                    scan_done_q, scan_done_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_f_q, rsp_f_d;
    logic [3:0]              rsp_x_q, rsp_x_d;
    logic [ID_W-1:0]         rsp_id_q, rsp_id_d;

    logic [N_REQ-1:0][3:0]   req_x_a;
    logic [N_REQ-1:0]        ready_c;
    logic [ID_W-1:0]         gnt_id;
    logic                    gnt_any;
    logic                    take;
    logic                    can_accept;

    assign req_x_a    = req_x;
    assign can_accept = !rsp_valid_q || rsp_ready;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping.
    always_comb begin
        int idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end

    // Next-state: config beats scan start beats grants; the slot drains in every state.
    always_comb begin
        state_d    = state_q;
        table_d    = table_q;
        rr_ptr_d   = rr_ptr_q;
        scan_x_d   = scan_x_q;
        scan_map_d = scan_map_q;
        rsp_valid_d = rsp_valid_q;
        rsp_f_d    = rsp_f_q;
        rsp_x_d    = rsp_x_q;
        rsp_id_d   = rsp_id_q;
        ready_c    = '0;
        take       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    table_d = cfg_table;
                end else if (scan_start) begin
                    state_d  = SCAN;
                    scan_x_d = 4'd0;
                end else if (can_accept && gnt_any) begin
                    ready_c[gnt_id] = 1'b1;
                    take            = 1'b1;
                end
            end
            SCAN: begin
                scan_map_d[scan_x_q] = table_q[scan_x_q];
                scan_x_d             = scan_x_q + 4'd1;
                if (scan_x_q == 4'd15) state_d = SDONE;
            end
            SDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (take) begin
            rsp_valid_d = 1'b1;
            rsp_f_d     = table_q[req_x_a[gnt_id]];
            rsp_x_d     = req_x_a[gnt_id];
            rsp_id_d    = gnt_id;
            rr_ptr_d    = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        scan_busy_d = (state_d == SCAN);
        scan_done_d = (state_d == SDONE);
    end

    // State and registered outputs; reset discards any in-flight scan or response.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q     <= IDLE;
            table_q     <= RESET_TABLE;
            rr_ptr_q    <= '0;
            scan_x_q    <= '0;
            scan_map_q  <= '0;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_f_q     <= 1'b0;
            rsp_x_q     <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            table_q     <= table_d;
            rr_ptr_q    <= rr_ptr_d;
            scan_x_q    <= scan_x_d;
            scan_map_q  <= scan_map_d;
            scan_busy_q <= scan_busy_d;
            scan_done_q <= scan_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_f_q     <= rsp_f_d;
            rsp_x_q     <= rsp_x_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // Accept is combinational but forced low while reset is held.
    assign req_ready = ready_c & {N_REQ{areset_n}};
    assign rsp_valid = rsp_valid_q;
    assign rsp_f     = rsp_f_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_id    = rsp_id_q;
    assign scan_busy = scan_busy_q;
    assign scan_done = scan_done_q;
    assign scan_map  = scan_map_q;

endmodule

// File: tb/tb_kmap_eval_arbiter.sv
// Directed bench for kmap_eval_arbiter: vector tables for single-requester and
// round-robin traffic, hand sequences for backpressure, config, scan and reset.
module tb_kmap_eval_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          areset_n;
    logic [N-1:0]  req_valid;
    logic [4*N-1:0] req_x;
    logic [N-1:0]  req_ready;
    logic          rsp_valid, rsp_f;
    logic [3:0]    rsp_x;
    logic [1:0]    rsp_id;
    logic          rsp_ready, cfg_we, scan_start;
    logic [15:0]   cfg_table;
    logic          scan_busy, scan_done;
    logic [15:0]   scan_map;

    int checks = 0;
    int errors = 0;

    typedef struct {logic [3:0] x; logic f;} vec1_t;
    typedef struct {logic [3:0] rdy; logic [1:0] id; logic f;} vec2_t;
    vec1_t v1[16];
    vec2_t v2[8];

    always #5 clk = ~clk;

    kmap_eval_arbiter #(.N_REQ(N), .ID_W(2), .RESET_TABLE(16'hD073)) dut (
        .clk(clk), .areset_n(areset_n),
        .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_f(rsp_f), .rsp_x(rsp_x), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready), .cfg_we(cfg_we), .cfg_table(cfg_table),
        .scan_start(scan_start), .scan_busy(scan_busy), .scan_done(scan_done),
        .scan_map(scan_map)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        #3;
        areset_n = 1'b1;
        step();
    endtask

    // Runs one scan from IDLE; optionally pulses cfg_we mid-scan with an all-zero table.
    task automatic run_scan(input bit mid_cfg, output int busy_n, output int done_n,
                            output int rdy_n);
        busy_n = 0; done_n = 0; rdy_n = 0;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mid_cfg && c == 5) begin
                cfg_we = 1'b1; cfg_table = 16'h0000;
            end else begin
                cfg_we = 1'b0;
            end
            #1;
            if (scan_busy) busy_n++;
            if (scan_done) done_n++;
            if ((scan_busy || scan_done) && req_ready != '0) rdy_n++;
            step();
        end
        cfg_we = 1'b0;
    endtask

    initial begin
        int busy_n, done_n, rdy_n;
        v1[0]  = '{4'h0, 1'b1}; v1[1]  = '{4'h1, 1'b1}; v1[2]  = '{4'h2, 1'b0};
        v1[3]  = '{4'h3, 1'b0}; v1[4]  = '{4'h4, 1'b1}; v1[5]  = '{4'h5, 1'b1};
        v1[6]  = '{4'h6, 1'b1}; v1[7]  = '{4'h7, 1'b0}; v1[8]  = '{4'h8, 1'b0};
        v1[9]  = '{4'h9, 1'b0}; v1[10] = '{4'hA, 1'b0}; v1[11] = '{4'hB, 1'b0};
        v1[12] = '{4'hC, 1'b1}; v1[13] = '{4'hD, 1'b0}; v1[14] = '{4'hE, 1'b1};
        v1[15] = '{4'hF, 1'b1};
        for (int i = 0; i < 8; i++) begin
            v2[i].rdy = 4'b0001 << (i % 4);
            v2[i].id  = 2'(i % 4);
            v2[i].f   = (i % 2 == 0) ? 1'b1 : 1'b0;
        end

        areset_n = 1'b0; req_valid = '0; req_x = '0; rsp_ready = 1'b0;
        cfg_we = 1'b0; cfg_table = '0; scan_start = 1'b0;
        #12;
        req_valid = 4'hF;
        #1;
        chk("reset_req_ready", 32'(req_ready), 0);
        chk("reset_rsp", {rsp_valid, rsp_f, rsp_x, rsp_id}, 0);
        chk("reset_scan", {scan_busy, scan_done, scan_map}, 0);
        req_valid = '0;
        @(negedge clk);
        areset_n = 1'b1;
        step();

        // single requester sweeps x = 0..15
        for (int i = 0; i < 16; i++) begin
            req_valid = 4'b0001; req_x = {12'h0, v1[i].x}; rsp_ready = 1'b1;
            #1;
            chk($sformatf("seq_ready[%0d]", i), 32'(req_ready), 32'h1);
            step();
            chk($sformatf("seq_rsp[%0d]", i), {rsp_valid, rsp_f, rsp_x, rsp_id},
                {1'b1, v1[i].f, v1[i].x, 2'd0});
        end
        req_valid = '0;

        // round robin with all four requesting
        do_reset();
        req_valid = 4'hF; req_x = {4'hD, 4'hC, 4'h2, 4'h0}; rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("rr_ready[%0d]", i), 32'(req_ready), 32'(v2[i].rdy));
            step();
            chk($sformatf("rr_rsp[%0d]", i), {rsp_valid, rsp_f, rsp_id},
                {1'b1, v2[i].f, v2[i].id});
        end
        req_valid = '0;
        step();

        // backpressure: slot holds for 5 cycles, then same-cycle regrant
        rsp_ready = 1'b0; req_valid = 4'b0100; req_x = 16'h0600;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = 4'b0010; req_x = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_hold[%0d]", i), {rsp_valid, rsp_f, rsp_x, rsp_id},
                {1'b1, 1'b1, 4'h6, 2'd2});
            chk($sformatf("bp_noready[%0d]", i), 32'(req_ready), 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_regrant", 32'(req_ready), 32'h2);
        step();
        chk("bp_regrant_rsp", {rsp_valid, rsp_f, rsp_id}, {1'b1, 1'b1, 2'd1});
        req_valid = '0;
        step();
        chk("bp_drain", 32'(rsp_valid), 0);

        // config beats a same-cycle request, new table used afterwards
        cfg_we = 1'b1; cfg_table = 16'h8001; req_valid = 4'b0010; req_x = 16'h00F0;
        #1;
        chk("cfg_blocks_grant", 32'(req_ready), 0);
        step();
        cfg_we = 1'b0;
        #1;
        chk("cfg_after_grant", 32'(req_ready), 32'h2);
        step();
        chk("cfg_f_xF", {rsp_valid, rsp_f, rsp_x}, {1'b1, 1'b1, 4'hF});
        req_x = 16'h0040;
        step();
        chk("cfg_f_x4", {rsp_valid, rsp_f, rsp_x}, {1'b1, 1'b0, 4'h4});
        req_valid = '0;
        step();

        // scan with default table; requester 0 keeps asking throughout
        do_reset();
        req_valid = 4'b0001; req_x = 16'h0003; rsp_ready = 1'b1;
        run_scan(1'b0, busy_n, done_n, rdy_n);
        chk("scan1_busy_cycles", 32'(busy_n), 16);
        chk("scan1_done_pulses", 32'(done_n), 1);
        chk("scan1_no_grant", 32'(rdy_n), 0);
        chk("scan1_map", 32'(scan_map), 32'hD073);

        // scan after cfg FFFF, with a mid-scan cfg that must be ignored
        req_valid = '0;
        cfg_we = 1'b1; cfg_table = 16'hFFFF;
        step();
        cfg_we = 1'b0;
        run_scan(1'b1, busy_n, done_n, rdy_n);
        chk("scan2_busy_cycles", 32'(busy_n), 16);
        chk("scan2_map", 32'(scan_map), 32'hFFFF);
        req_valid = 4'b0001; req_x = 16'h0003;
        step();
        chk("scan2_table_kept", {rsp_valid, rsp_f, rsp_x}, {1'b1, 1'b1, 4'h3});
        req_valid = '0;
        step();

        // reset at scan cycle 7 with a held response
        cfg_we = 1'b1; cfg_table = 16'hFF00;
        step();
        cfg_we = 1'b0;
        rsp_ready = 1'b0; req_valid = 4'b0001; req_x = 16'h0001;
        step();
        req_valid = '0;
        chk("rst_pre_rsp", 32'(rsp_valid), 1);
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        repeat (7) step();
        chk("rst_pre_scan", {scan_busy, rsp_valid}, 2'b11);
        #2;
        areset_n = 1'b0;
        #1;
        chk("rst_mid_rsp", 32'(rsp_valid), 0);
        chk("rst_mid_scan", {scan_busy, scan_done, scan_map}, 0);
        #2;
        areset_n = 1'b1;
        step();
        req_valid = 4'b0001; req_x = 16'h0000; rsp_ready = 1'b1;
        #1;
        chk("rst_post_ready", 32'(req_ready), 32'h1);
        step();
        chk("rst_post_table", {rsp_valid, rsp_f, rsp_x}, {1'b1, 1'b1, 4'h0});
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
